// File: rtl/fmul_norm_acc.sv
// rtl/fmul_norm_acc.sv - multi-cycle Booth partial-product accumulator with normalize, RNE round and IEEE single pack
// Build option FMUL_NORM_DUAL_ADD_EN: accumulate two partial products per ACC cycle.
module fmul_norm_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:0] P0,
  input  logic [48:0] P1,
  input  logic [48:0] P2,
  input  logic [48:0] P3,
  input  logic [48:0] P4,
  input  logic [48:0] P5,
  input  logic [48:0] P6,
  input  logic [48:0] P7,
  input  logic [48:0] P8,
  input  logic [48:0] P9,
  input  logic [48:0] P10,
  input  logic [48:0] P11,
  input  logic [48:0] P12,
  input  logic        sign,
  input  logic [8:0]  expc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {IDLE, ACC, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [48:0] pp_q [13];
  logic [48:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sign_q;
  logic [8:0]  expc_q;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;

  logic [48:0] term;
  logic        last_term;
  logic [3:0]  step;

`ifdef FMUL_NORM_DUAL_ADD_EN
  always_comb begin
    term = pp_q[cnt_q];
    if (cnt_q < 4'd12) term = pp_q[cnt_q] + pp_q[cnt_q + 4'd1];
  end
  assign last_term = (cnt_q >= 4'd12);
  assign step      = 4'd2;
`else
  assign term      = pp_q[cnt_q];
  assign last_term = (cnt_q == 4'd12);
  assign step      = 4'd1;
`endif

  // Bit 48 of the sum only absorbs Booth sign-extension carries.
  logic        unused_acc_msb;
  assign unused_acc_msb = acc_q[48];

  logic [47:0]        p;
  logic               n;
  logic [22:0]        mant_pre, mant;
  logic               guard, sticky, rnd, carry;
  logic signed [10:0] exp_s, e;

  always_comb begin
    p = acc_q[47:0];
    n = p[47];
    if (n) begin
      mant_pre = p[46:24];
      guard    = p[23];
      sticky   = |p[22:0];
    end else begin
      mant_pre = p[45:23];
      guard    = p[22];
      sticky   = |p[21:0];
    end
    rnd = guard && (sticky || mant_pre[0]);
    {carry, mant} = {1'b0, mant_pre} + {23'd0, rnd};
    // Biased exponents of 384 and above encode negative values.
    exp_s = (expc_q >= 9'd384) ? $signed({2'b00, expc_q}) - 11'sd512
                               : $signed({2'b00, expc_q});
    e = exp_s + $signed({10'd0, n}) + $signed({10'd0, carry});
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + term;
        cnt_d = cnt_q + step;
        if (last_term) state_d = NORM;
      end
      NORM: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (e >= 11'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (e <= 11'sd0) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, e[7:0], mant};
        end
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 13; i++) pp_q[i] <= '0;
      sign_q <= 1'b0;
      expc_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      pp_q[0]  <= P0;
      pp_q[1]  <= P1;
      pp_q[2]  <= P2;
      pp_q[3]  <= P3;
      pp_q[4]  <= P4;
      pp_q[5]  <= P5;
      pp_q[6]  <= P6;
      pp_q[7]  <= P7;
      pp_q[8]  <= P8;
      pp_q[9]  <= P9;
      pp_q[10] <= P10;
      pp_q[11] <= P11;
      pp_q[12] <= P12;
      sign_q   <= sign;
      expc_q   <= expc;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: doc/fmul_norm_acc.md
# fmul_norm_acc

Sequential back end of the single-precision multiplier. Accepts the 13 radix-4 Booth partial products, product sign and provisional biased exponent from the partial-product generator. Sums the partial products over multiple cycles, normalizes, rounds to nearest-even and packs an IEEE-754 single result behind a valid/ready handshake. Sits between the partial-product generator and the FPU result mux.

## Interface
- No parameters; feature selection via macro (see Configuration).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  block can accept a bundle.
- P0..P12  in  49 each  sign-extended, pre-shifted partial products; sum mod 2^49 equals the 48-bit mantissa product.
- sign  in  1  product sign.
- expc  in  9  eA+eB-127 mod 512.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  32  packed IEEE single.
- ovf  out  1  overflow flag, qualified by out_valid.
- unf  out  1  underflow/flush flag, qualified by out_valid.

## Operation
- States: IDLE, ACC, NORM, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register P0..P12, sign and expc, clear 49-bit acc and term counter, go to ACC. Inputs need not be held after the accept cycle.
- ACC: acc += P[cnt] mod 2^49 each cycle, cnt 0..12. After the P12 add, go to NORM.
- NORM: p = acc[47:0]. acc[48] is always 0 for legal inputs and is not checked.
  - If p[47]=1: n=1, mant=p[46:24], guard=p[23], sticky=|p[22:0].
  - Else: n=0, mant=p[45:23], guard=p[22], sticky=|p[21:0].
  - Round up if guard&&(sticky||mant[0]). Mantissa carry-out sets mant=0 and adds 1 to the exponent.
  - Exponent: expc values ≥384 are interpreted as negative (expc-512). e = that + n + round carry, computed in 11-bit signed.
  - e≥255: result={sign,8'hFF,23'b0}, ovf=1. e≤0: result={sign,31'b0}, unf=1. Otherwise result={sign,e[7:0],mant}.
  - Register result and flags, go to DONE.
- DONE: out_valid=1; result and flags held stable. On out_ready, go to IDLE.
- No special-casing of zero, denormal, inf or NaN operands; upstream always supplies the hidden 1.
- in_ready=0 in ACC, NORM and DONE.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, ovf=0, unf=0, acc=0, cnt=0.
- Latency: the accept edge starts ACC. out_valid rises 14 clocks after the accept edge (13 ACC + 1 NORM).
- Throughput: one operation per 15 cycles minimum (accept, 13 ACC, NORM) plus the DONE→IDLE handshake cycle.
- out_valid&&out_ready at edge k: out_valid=0 and in_ready=1 after edge k. A new accept is possible at edge k+1.
- Reset asserted in any state: immediate return to IDLE with all outputs at reset values. The in-flight operation is discarded.
- in_valid while busy is ignored; upstream must hold it until in_ready.

## Configuration
- FMUL_NORM_DUAL_ADD_EN defined: ACC adds two terms per cycle (P[2i]+P[2i+1]), with P12 alone in the 7th cycle. ACC lasts 7 cycles, and out_valid rises 8 clocks after the accept edge.
- Undefined: one term per cycle, 13 ACC cycles, latency 14.
- Rounding, flags and handshake are identical in both builds.

## Test plan
- 0x3F800000×0x3F800000 (bundle from the generator) -> result 0x3F800000, ovf=unf=0, out_valid exactly 14 clocks after accept (8 with FMUL_NORM_DUAL_ADD_EN).
- 0x3FC00000×0x3FC00000 -> 0x40100000 (n=1 path). 0x40400000×0xC0000000 -> 0xC0C00000.
- 0x3F800001×0x3F800001 -> 0x3F800002 (guard=0, truncated sticky).
- 0x7F000000×0x40000000 (expc=255) -> 0x7F800000, ovf=1. 0x00800000×0x00800000 (expc=387) -> 0x00000000, unf=1.
- Hold out_ready=0 for 5 cycles in DONE -> result, flags and out_valid stable, in_ready=0. Release -> in_ready=1 next cycle. Back-to-back second operation is correct.
- Assert rst at ACC cycle 6 -> out_valid=0, in_ready=1 immediately. A following 1.0×1.0 operation returns 0x3F800000.
